// File: rtl/scroll_collide_pkg.sv
// Shared game constants: jump-state encoding, obstacle layout, default geometry.
package scroll_collide_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_e;

    localparam logic [7:0] DEFAULT_SCREEN_END = 8'd159;
    localparam logic [6:0] DEFAULT_GROUND_Y   = 7'd100;

    localparam int         NUM_OBST = 4;
    localparam logic [7:0] OBST_W   = 8'd8;
    localparam logic [6:0] OBST_H   = 7'd12;

    // Left column of each obstacle; entry 0 is the first one the player meets.
    localparam logic [NUM_OBST-1:0][7:0] OBST_START = {8'd136, 8'd104, 8'd72, 8'd40};

endpackage

// File: rtl/scroll_collide_obstacle_hit.sv
// Combinational overlap test between the player position and the fixed obstacles.
module obstacle_hit
    import scroll_collide_pkg::*;
#(
    parameter logic [6:0] GROUND_Y = DEFAULT_GROUND_Y
) (
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    output logic       hit
);

    // Rows strictly below this line are inside an obstacle's height.
    localparam logic [6:0] TOP_ROW = GROUND_Y - OBST_H;

    logic in_span;

    // Column check against every obstacle span.
    always_comb begin
        in_span = 1'b0;
        for (int i = 0; i < NUM_OBST; i++) begin
            if (player_x >= OBST_START[i] && (player_x - OBST_START[i]) < OBST_W)
                in_span = 1'b1;
        end
    end

    assign hit = in_span && (player_y > TOP_ROW);

endmodule

// File: rtl/scroll_collide.sv
// Side-scroller player motion: x advance, jump arc FSM and sticky end-of-run flags.
module scroll_collide
    import scroll_collide_pkg::*;
#(
    parameter logic [7:0] SCREEN_END  = DEFAULT_SCREEN_END,
    parameter logic [6:0] GROUND_Y    = DEFAULT_GROUND_Y,
    parameter logic [6:0] JUMP_HEIGHT = 7'd24,
    parameter logic [6:0] JUMP_STEP   = 7'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       frame_tick,
    input  logic       jump,
    output logic [7:0] player_x,
    output logic [6:0] player_y,
    output logic       collided,
    output logic       reached_screen_end
);

    localparam logic [6:0] APEX     = GROUND_Y - JUMP_HEIGHT;
    // A rise step from at or above this row would overshoot the apex.
    localparam logic [7:0] RISE_LIM = {1'b0, APEX} + {1'b0, JUMP_STEP};

    jump_state_e state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic        col_q, col_d;
    logic        end_q, end_d;
    logic        hit;

    obstacle_hit #(.GROUND_Y(GROUND_Y)) u_hit (
        .player_x (x_q),
        .player_y (y_q),
        .hit      (hit)
    );

    // Next-state: run=0 clears the game; flags freeze all motion once set.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        end_d   = end_q;
        if (!run) begin
            state_d = GROUND;
            x_d     = 8'd0;
            y_d     = GROUND_Y;
            col_d   = 1'b0;
            end_d   = 1'b0;
        end else begin
            col_d = col_q | hit;
            end_d = end_q | (x_q == SCREEN_END);
            if (frame_tick && !col_q && !end_q) begin
                x_d = (x_q == SCREEN_END) ? x_q : x_q + 8'd1;
                unique case (state_q)
                    GROUND: if (jump) state_d = RISE;
                    RISE: begin
                        if ({1'b0, y_q} <= RISE_LIM) begin
                            y_d     = APEX;
                            state_d = FALL;
                        end else begin
                            y_d = y_q - JUMP_STEP;
                        end
                    end
                    FALL: begin
                        if (({1'b0, y_q} + {1'b0, JUMP_STEP}) >= {1'b0, GROUND_Y}) begin
                            y_d     = GROUND_Y;
                            state_d = GROUND;
                        end else begin
                            y_d = y_q + JUMP_STEP;
                        end
                    end
                    default: state_d = GROUND;
                endcase
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= GROUND;
            x_q     <= 8'd0;
            y_q     <= GROUND_Y;
            col_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            end_q   <= end_d;
        end
    end

    assign player_x           = x_q;
    assign player_y           = y_q;
    assign collided           = col_q;
    assign reached_screen_end = end_q;

endmodule

// File: tb/tb_scroll_collide.sv
// Scoreboard bench for scroll_collide: expected positions are queued per frame tick.
module tb_scroll_collide;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       col;
        logic       fin;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jump = 1'b0;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic       collided;
    logic       reached_screen_end;

    int   checks = 0;
    int   fails  = 0;
    obs_t sb[$];
    obs_t got, exp_o;

    scroll_collide dut (
        .clock              (clock),
        .reset              (reset),
        .run                (run),
        .frame_tick         (frame_tick),
        .jump               (jump),
        .player_x           (player_x),
        .player_y           (player_y),
        .collided           (collided),
        .reached_screen_end (reached_screen_end)
    );

    always #5 clock = ~clock;

    // y for the k-th tick of a jump (k=0 is the tick that starts it).
    function automatic logic [6:0] yfor(input int k);
        if (k <= 0)       return 7'd100;
        else if (k <= 12) return 7'(100 - 2 * k);
        else              return 7'(76 + 2 * (k - 12));
    endfunction

    function automatic obs_t mk(input int x, input int y, input logic c, input logic f);
        obs_t o;
        o.x = 8'(x); o.y = 7'(y); o.col = c; o.fin = f;
        return o;
    endfunction

    // One frame tick; returns at the following negedge with outputs settled.
    task automatic drive_tick(input logic j);
        @(negedge clock);
        frame_tick = 1'b1;
        jump = j;
        @(negedge clock);
        frame_tick = 1'b0;
        jump = 1'b0;
        got = '{player_x, player_y, collided, reached_screen_end};
    endtask

    task automatic idle_clk();
        @(negedge clock);
        got = '{player_x, player_y, collided, reached_screen_end};
    endtask

    // Drop run for one clock to start a fresh game.
    task automatic restart();
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        run = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        got = '{player_x, player_y, collided, reached_screen_end};
        checks++;
        if (got !== mk(0, 100, 0, 0)) begin
            fails++; $display("FAIL reset_initial got=%h exp=%h", got, mk(0, 100, 0, 0));
        end
        @(negedge clock);
        reset = 1'b0;
        run = 1'b1;
        for (int i = 1; i <= 5; i++) drive_tick(1'b0);
        checks++;
        if (got !== mk(5, 100, 0, 0)) begin
            fails++; $display("FAIL pre_reset_walk got=%h exp=%h", got, mk(5, 100, 0, 0));
        end
        drive_tick(1'b1);
        drive_tick(1'b0);
        // Mid-jump, asserted between edges: must act without a clock.
        #2 reset = 1'b1;
        #1 got = '{player_x, player_y, collided, reached_screen_end};
        checks++;
        if (got !== mk(0, 100, 0, 0)) begin
            fails++; $display("FAIL async_reset got=%h exp=%h", got, mk(0, 100, 0, 0));
        end
        @(negedge clock);
        reset = 1'b0;
        drive_tick(1'b0);
        checks++;
        if (got !== mk(1, 100, 0, 0)) begin
            fails++; $display("FAIL first_tick_after_reset got=%h exp=%h", got, mk(1, 100, 0, 0));
        end
    endtask

    task automatic test_walk_collide();
        restart();
        for (int t = 1; t <= 40; t++) begin
            sb.push_back(mk(t, 100, 0, 0));
            drive_tick(1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (got !== exp_o) begin
                fails++; $display("FAIL walk t=%0d got=%h exp=%h", t, got, exp_o);
            end
        end
        sb.push_back(mk(40, 100, 1, 0));
        idle_clk();
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o) begin
            fails++; $display("FAIL collide_flag got=%h exp=%h", got, exp_o);
        end
        for (int t = 0; t < 5; t++) begin
            sb.push_back(mk(40, 100, 1, 0));
            drive_tick(1'b1);
            exp_o = sb.pop_front();
            checks++;
            if (got !== exp_o) begin
                fails++; $display("FAIL frozen t=%0d got=%h exp=%h", t, got, exp_o);
            end
        end
    endtask

    task automatic test_run_clear();
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        got = '{player_x, player_y, collided, reached_screen_end};
        checks++;
        if (got !== mk(0, 100, 0, 0)) begin
            fails++; $display("FAIL run_clear got=%h exp=%h", got, mk(0, 100, 0, 0));
        end
        drive_tick(1'b1);
        checks++;
        if (got !== mk(0, 100, 0, 0)) begin
            fails++; $display("FAIL tick_while_idle got=%h exp=%h", got, mk(0, 100, 0, 0));
        end
        run = 1'b1;
    endtask

    task automatic test_jump_clear();
        restart();
        for (int t = 1; t <= 55; t++) begin
            // Jump on the tick taken at x=30 (tick 31).
            sb.push_back(mk(t, (t > 31) ? yfor(t - 31) : 100, 0, 0));
            drive_tick(t == 31);
            exp_o = sb.pop_front();
            checks++;
            if (got !== exp_o) begin
                fails++; $display("FAIL jump_arc t=%0d got=%h exp=%h", t, got, exp_o);
            end
        end
    endtask

    task automatic test_screen_end();
        int k;
        logic j;
        k = -1;
        restart();
        for (int t = 1; t <= 159; t++) begin
            j = (t - 1 == 30) || (t - 1 == 62) || (t - 1 == 94) || (t - 1 == 126);
            if (j) k = 0;
            else if (k >= 0 && k < 24) k++;
            else k = -1;
            sb.push_back(mk(t, (k < 0) ? 100 : yfor(k), 0, 0));
            drive_tick(j);
            exp_o = sb.pop_front();
            checks++;
            if (got !== exp_o) begin
                fails++; $display("FAIL run_to_end t=%0d got=%h exp=%h", t, got, exp_o);
            end
        end
        sb.push_back(mk(159, 100, 0, 1));
        idle_clk();
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o) begin
            fails++; $display("FAIL end_flag got=%h exp=%h", got, exp_o);
        end
        for (int t = 0; t < 3; t++) begin
            sb.push_back(mk(159, 100, 0, 1));
            drive_tick(1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (got !== exp_o) begin
                fails++; $display("FAIL end_hold t=%0d got=%h exp=%h", t, got, exp_o);
            end
        end
    endtask

    task automatic test_jump_hold();
        restart();
        // Held button: a 25-tick cycle, re-launch only once back on the ground.
        for (int t = 1; t <= 39; t++) begin
            sb.push_back(mk(t, yfor((t - 1) % 25), 0, 0));
            drive_tick(1'b1);
            exp_o = sb.pop_front();
            checks++;
            if (got !== exp_o) begin
                fails++; $display("FAIL jump_hold t=%0d got=%h exp=%h", t, got, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk_collide();
        test_run_clear();
        test_jump_clear();
        test_screen_end();
        test_jump_hold();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
